// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS execute-stage multiply/divide unit.
// Latency: none (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: muldiv_op_t operation codes, muldiv_state_t FSM states,
//           md_is_signed() which flags the signed operations.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } muldiv_state_t;

  // MULT and DIV treat their operands as two's complement.
  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One radix-2 iteration of shift-add multiply or restoring divide.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register acc_out.
// Ports: acc_in  - {upper, lower} accumulator (product/multiplier or remainder/quotient)
//        opnd    - multiplicand (multiply) or divisor (divide) magnitude
//        is_div  - 1 selects the divide step, 0 the multiply step
//        acc_out - accumulator after this iteration
module mips_cpu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  always_comb begin
    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit (lsb) is set, then shift everything right; the carry
    // bit becomes the new msb.
    sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);

    // Divide: shift the partial remainder left pulling in the next dividend
    // bit. The shifted remainder can reach WIDTH+1 bits, so compare there.
    rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
    trial  = rem_sh - {1'b0, opnd};

    if (is_div) begin
      if (trial[WIDTH]) begin
        // Borrow: divisor did not fit, keep the shifted remainder.
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the MIPS execute stage.
// Latency: mul/div busy for WIDTH+1 cycles (WIDTH RUN + 1 FIX), done pulses as busy drops; MTHI/MTLO 1 edge.
// Backpressure: start is only honoured in IDLE; the CPU stalls on busy. Starts while busy are dropped.
// Ports: clk, reset (async active-high), start, op[2:0], rs_content, rt_content,
//        busy, done (1-cycle pulse), hi, lo.
// Optional: MIPS_MULDIV_FAST_MUL_EN gives MULT/MULTU a single-cycle array multiply (IDLE -> FIX).
module mips_cpu_muldiv_unit
  import mips_cpu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t      state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   dvd_raw;   // original dividend, returned in HI on divide by zero
  logic               is_div;
  logic               neg_q;     // negate product / quotient
  logic               neg_r;     // negate remainder (dividend was negative)
  logic               div_zero;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Magnitudes: negating the most-negative value yields 2^(WIDTH-1), which
  // is exactly its unsigned magnitude, so no overflow case is needed here.
  always_comb begin
    a_neg    = md_is_signed(op) & rs_content[WIDTH-1];
    b_neg    = md_is_signed(op) & rt_content[WIDTH-1];
    mag_a    = a_neg ? (~rs_content + 1'b1) : rs_content;
    mag_b    = b_neg ? (~rt_content + 1'b1) : rt_content;
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    quo_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc),
    .opnd    (opnd),
    .is_div  (is_div),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      dvd_raw  <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU: begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
                acc   <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                state <= MD_FIX;
`else
                acc   <= {{WIDTH{1'b0}}, mag_b};
                opnd  <= mag_a;
                state <= MD_RUN;
`endif
                is_div   <= 1'b0;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= 1'b0;
                div_zero <= 1'b0;
                cnt      <= '0;
                busy     <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                acc      <= {{WIDTH{1'b0}}, mag_a};
                opnd     <= mag_b;
                dvd_raw  <= rs_content;
                is_div   <= 1'b1;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (rt_content == '0);
                cnt      <= '0;
                busy     <= 1'b1;
                state    <= MD_RUN;
              end
              MD_MTHI: hi <= rs_content;
              MD_MTLO: lo <= rs_content;
              default: ;  // reserved ops are silently ignored
            endcase
          end
        end
        MD_RUN: begin
          acc <= acc_next;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= MD_FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MD_FIX: begin
          if (is_div) begin
            if (div_zero) begin
              lo <= '1;
              hi <= dvd_raw;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Directed self-checking bench for mips_cpu_muldiv_unit (WIDTH=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mips_cpu_muldiv_unit;
  import mips_cpu_pkg::*;

`ifdef MIPS_MULDIV_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_content = '0;
  logic [31:0] rt_content = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  mips_cpu_muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .rs_content (rs_content),
    .rt_content (rt_content),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Issue one operation, scramble the operand inputs right after acceptance,
  // then watch a fixed window counting busy cycles and done pulses.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output int dcnt);
    @(negedge clk);
    op = o; rs_content = a; rt_content = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rs_content = $urandom; rt_content = $urandom;
    bcyc = busy ? 1 : 0;
    dcnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) dcnt++;
    end
  endtask

  task automatic test_reset;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_multu;
    int b, d;
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, b, d);
    tests++; if (hi !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    tests++; if (lo !== 32'h00000001) begin fails++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    tests++; if (b != MUL_BUSY) begin fails++; $display("FAIL multu_busy_cycles: got %0d expected %0d", b, MUL_BUSY); end
    tests++; if (d != 1) begin fails++; $display("FAIL multu_done_pulses: got %0d expected 1", d); end
  endtask

  task automatic test_mult;
    int b, d;
    run_op(MD_MULT, 32'hFFFFFFFD, 32'd7, b, d);
    tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
    tests++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", lo); end
    tests++; if (d != 1) begin fails++; $display("FAIL mult_neg_done: got %0d expected 1", d); end
    run_op(MD_MULT, 32'h80000000, 32'h80000000, b, d);
    tests++; if (hi !== 32'h40000000) begin fails++; $display("FAIL mult_minmin_hi: got %h expected 40000000", hi); end
    tests++; if (lo !== 32'h00000000) begin fails++; $display("FAIL mult_minmin_lo: got %h expected 00000000", lo); end
  endtask

  task automatic test_div;
    int b, d;
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, b, d);
    tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
    tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
    tests++; if (b != DIV_BUSY) begin fails++; $display("FAIL div_busy_cycles: got %0d expected %0d", b, DIV_BUSY); end
    run_op(MD_DIVU, 32'd7, 32'd2, b, d);
    tests++; if (lo !== 32'd3) begin fails++; $display("FAIL divu_lo: got %h expected 00000003", lo); end
    tests++; if (hi !== 32'd1) begin fails++; $display("FAIL divu_hi: got %h expected 00000001", hi); end
    tests++; if (d != 1) begin fails++; $display("FAIL divu_done: got %0d expected 1", d); end
  endtask

  task automatic test_div_edge;
    int b, d;
    run_op(MD_DIVU, 32'h00001234, 32'd0, b, d);
    tests++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL divu_zero_lo: got %h expected ffffffff", lo); end
    tests++; if (hi !== 32'h00001234) begin fails++; $display("FAIL divu_zero_hi: got %h expected 00001234", hi); end
    tests++; if (b != DIV_BUSY) begin fails++; $display("FAIL divu_zero_busy: got %0d expected %0d", b, DIV_BUSY); end
    run_op(MD_DIV, 32'hFFFFFFF8, 32'd0, b, d);
    tests++; if (lo !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_zero_lo: got %h expected ffffffff", lo); end
    tests++; if (hi !== 32'hFFFFFFF8) begin fails++; $display("FAIL div_zero_hi: got %h expected fffffff8", hi); end
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, b, d);
    tests++; if (lo !== 32'h80000000) begin fails++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
    tests++; if (hi !== 32'h00000000) begin fails++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_reserved;
    // hi=0, lo=80000000 from the previous case must survive op 6.
    @(negedge clk);
    op = 3'd6; rs_content = 32'h55555555; rt_content = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reserved_busy: got %b expected 0", busy); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reserved_hi: got %h expected 00000000", hi); end
    tests++; if (lo !== 32'h80000000) begin fails++; $display("FAIL reserved_lo: got %h expected 80000000", lo); end
  endtask

  task automatic test_back_to_back;
    bit got;
    // MTHI while idle: writes hi next edge, no busy/done.
    @(negedge clk);
    op = MD_MTHI; rs_content = 32'h11111111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (hi !== 32'h11111111) begin fails++; $display("FAIL mthi_hi: got %h expected 11111111", hi); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mthi_flags: got busy=%b done=%b expected 0 0", busy, done); end
    tests++; if (lo !== 32'h80000000) begin fails++; $display("FAIL mthi_lo_kept: got %h expected 80000000", lo); end
    // DIVU 100/7 = 14 r 2, with an MTHI attempt while busy.
    op = MD_DIVU; rs_content = 32'd100; rt_content = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    op = MD_MTHI; rs_content = 32'hDEADBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (hi !== 32'h11111111) begin fails++; $display("FAIL busy_mthi_hi: got %h expected 11111111", hi); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_mthi_busy: got %b expected 1", busy); end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL b2b_done_timeout: got no done expected done within 40 cycles");
    end else begin
      tests++; if (hi !== 32'd2) begin fails++; $display("FAIL b2b_div_hi: got %h expected 00000002", hi); end
      tests++; if (lo !== 32'd14) begin fails++; $display("FAIL b2b_div_lo: got %h expected 0000000e", lo); end
      // MTLO issued in the done cycle.
      op = MD_MTLO; rs_content = 32'hCAFEF00D; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++; if (lo !== 32'hCAFEF00D) begin fails++; $display("FAIL b2b_mtlo_lo: got %h expected cafef00d", lo); end
      tests++; if (hi !== 32'd2) begin fails++; $display("FAIL b2b_mtlo_hi: got %h expected 00000002", hi); end
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL b2b_mtlo_flags: got busy=%b done=%b expected 0 0", busy, done); end
    end
  endtask

  task automatic test_reset_mid;
    int b, d;
    int bc, dc;
    @(negedge clk);
    op = MD_DIV; rs_content = 32'd100; rt_content = 32'hFFFFFFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL midrst_hi: got %h expected 00000000", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL midrst_lo: got %h expected 00000000", lo); end
    @(negedge clk);
    reset = 1'b0;
    bc = 0; dc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc++;
    end
    tests++; if (dc != 0) begin fails++; $display("FAIL midrst_no_done: got %0d expected 0", dc); end
    tests++; if (bc != 0) begin fails++; $display("FAIL midrst_no_busy: got %0d expected 0", bc); end
    run_op(MD_DIVU, 32'd7, 32'd2, b, d);
    tests++; if (lo !== 32'd3 || hi !== 32'd1) begin fails++; $display("FAIL midrst_next_op: got hi=%h lo=%h expected hi=00000001 lo=00000003", hi, lo); end
    tests++; if (d != 1) begin fails++; $display("FAIL midrst_next_done: got %0d expected 1", d); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_edge();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
